fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline: owns PCF, issues instruction-memory reads, and drives the IF/ID

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns PCF, issues one instruction-memory read at a time, and drives the
// IF/ID register (InstrD/PCD/PCPlus4D/ValidD) consumed by decode.
// A one-entry hold buffer parks returned data while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pcf;
    logic [31:0] req_pc;
    logic        kill;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    logic        accepted;
    logic        wait_deliver;
    logic        hold_deliver;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;

    // Sequential PC increment; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // A redirect cycle never carries a request, so the stale PCF is never issued.
    assign imem_req  = (state == S_REQ) & ~PCSrcE & ~rst;
    assign imem_addr = pcf;
    assign accepted  = imem_req & imem_rdy;

    // Data reaches IF/ID either straight from memory or from the hold buffer.
    assign wait_deliver  = (state == S_WAIT) & imem_rvalid & ~kill & ~PCSrcE & ~StallF & ~FlushD;
    assign hold_deliver  = (state == S_HOLD) & ~PCSrcE & ~FlushD & ~StallF;
    assign deliver       = wait_deliver | hold_deliver;
    assign deliver_instr = (state == S_HOLD) ? hold_instr : imem_rdata;
    assign deliver_pc    = (state == S_HOLD) ? hold_pc    : req_pc;

    // Fetch control: PC sequencing, request/response tracking, kill flag and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pcf        <= RESET_PC;
            req_pc     <= RESET_PC;
            kill       <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    if (PCSrcE) begin
                        pcf <= PCTargetE;
                    end else if (accepted) begin
                        req_pc <= pcf;
                        pcf    <= pc_inc(pcf);
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A redirect always moves PCF; the in-flight read is only marked dead.
                    if (PCSrcE) begin
                        pcf <= PCTargetE;
                    end
                    if (imem_rvalid) begin
                        if (kill || PCSrcE) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (!StallF && !FlushD) begin
                            state <= S_REQ;
                        end else if (StallF) begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= req_pc;
                            state      <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (PCSrcE) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (PCSrcE) begin
                        pcf <= PCTargetE;
                    end
                    if (PCSrcE || FlushD || !StallF) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall beats delivery, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallF) begin
            if (deliver) begin
                InstrD   <= deliver_instr;
                PCD      <= deliver_pc;
                PCPlus4D <= pc_inc(deliver_pc);
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: acts as instruction memory and hazard unit, keeps a
// transaction-level model of the fetch stream, and checks the IF/ID register
// through a scoreboard queue drained by an independent monitor.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, StallF, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    ifid_t sb[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: next fetch address, the one memory read in flight,
    // whether a redirect has doomed it, and a returned-but-parked instruction.
    logic [31:0] exp_pc;
    logic        mem_pending;
    logic [31:0] mem_addr;
    logic        doomed;
    logic        held;
    logic [31:0] held_addr;
    logic        ret_now;
    ifid_t       exp_ifid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across the coming edge and queue the IF/ID it should produce.
    task automatic model_edge();
        logic        exp_req;
        logic        deliver;
        logic [31:0] d_pc;
        exp_req = !rst && !PCSrcE && !mem_pending && !held;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (!rst) check("imem_addr", imem_addr, exp_pc);
        if (rst) begin
            exp_pc         = RESET_PC;
            mem_pending    = 1'b0;
            doomed         = 1'b0;
            held           = 1'b0;
            exp_ifid.instr = NOP;
            exp_ifid.pc    = 32'd0;
            exp_ifid.pc4   = 32'd0;
            exp_ifid.valid = 1'b0;
        end else begin
            deliver = 1'b0;
            d_pc    = 32'd0;
            if (mem_pending) begin
                if (ret_now) begin
                    mem_pending = 1'b0;
                    if (doomed || PCSrcE) begin
                        // stale or redirected: thrown away
                    end else if (!StallF && !FlushD) begin
                        deliver = 1'b1;
                        d_pc    = mem_addr;
                    end else if (StallF) begin
                        held      = 1'b1;
                        held_addr = mem_addr;
                    end
                    doomed = 1'b0;
                end else if (PCSrcE) begin
                    doomed = 1'b1;
                end
            end else if (held) begin
                if (PCSrcE || FlushD) begin
                    held = 1'b0;
                end else if (!StallF) begin
                    deliver = 1'b1;
                    d_pc    = held_addr;
                    held    = 1'b0;
                end
            end
            if (exp_req && imem_rdy) begin
                mem_pending = 1'b1;
                mem_addr    = exp_pc;
                exp_pc      = exp_pc + 32'd4;
            end
            if (PCSrcE) exp_pc = PCTargetE;
            if (FlushD) begin
                exp_ifid.instr = NOP;
                exp_ifid.valid = 1'b0;
            end else if (!StallF) begin
                if (deliver) begin
                    exp_ifid.instr = mem_word(d_pc);
                    exp_ifid.pc    = d_pc;
                    exp_ifid.pc4   = d_pc + 32'd4;
                    exp_ifid.valid = 1'b1;
                end else begin
                    exp_ifid.instr = NOP;
                    exp_ifid.valid = 1'b0;
                end
            end
        end
        sb.push_back(exp_ifid);
    endtask

    // One clock cycle of stimulus: control inputs, memory ready, and whether the
    // memory returns its pending read (ret) or emits a stray rvalid when idle.
    task automatic step(input logic r, input logic sf, input logic fd, input logic ps,
                        input logic [31:0] tgt, input logic rdy, input logic ret,
                        input logic stray);
        @(posedge clk);
        #1;
        rst       = r;
        StallF    = sf;
        FlushD    = fd;
        PCSrcE    = ps;
        PCTargetE = tgt;
        imem_rdy  = rdy;
        ret_now   = mem_pending && ret;
        if (ret_now) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
        end else if (!mem_pending && stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        #1;
        model_edge();
    endtask

    // Monitor: every cycle the IF/ID register is compared with the next queued expectation.
    initial begin : monitor
        ifid_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({InstrD, PCD, PCPlus4D, ValidD} !== e) begin
                    bad++;
                    $display("FAIL ifid: got instr=%h pc=%h pc4=%h v=%b expected instr=%h pc=%h pc4=%h v=%b at %0t",
                             InstrD, PCD, PCPlus4D, ValidD, e.instr, e.pc, e.pc4, e.valid, $time);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
        imem_rdy = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        exp_pc = RESET_PC; mem_pending = 1'b0; mem_addr = 32'd0; doomed = 1'b0;
        held = 1'b0; held_addr = 32'd0; ret_now = 1'b0;
        exp_ifid = '0;

        // reset, then straight-line fetch of 0x0, 0x4, 0x8
        repeat (2) step(1, 0, 0, 0, 32'd0, 1, 0, 0);
        repeat (6) step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        // memory not ready for three cycles at PC 0xC
        repeat (3) step(0, 0, 0, 0, 32'd0, 0, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        // data for 0x10 returns under stall, parked, then released
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 1, 0, 0, 32'd0, 1, 1, 0);
        step(0, 1, 0, 0, 32'd0, 1, 0, 1);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        // redirect while waiting on 0x14: late data dropped, refetch from 0x100
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 1, 32'h100, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        // flush and stall together over a valid IF/ID
        step(0, 1, 1, 0, 32'd0, 0, 0, 0);
        // reset in the middle of a read, then a stray rvalid before the first accept
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(1, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 0, 0, 1);
        step(0, 0, 0, 0, 32'd0, 1, 0, 1);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        // PC wrap at the top of the address space
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        // redirect in the same cycle the data returns
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 1, 32'h200, 1, 1, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);
        // flush on return, flush while parked, redirect while parked
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 1, 0, 32'd0, 1, 1, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 1, 0, 0, 32'd0, 1, 1, 0);
        step(0, 0, 1, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 1, 0, 0, 32'd0, 1, 1, 0);
        step(0, 1, 0, 1, 32'h300, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 0, 32'd0, 1, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2))
                                              : (32'($urandom_range(0, 1023)) << 2);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0,
                 tgt,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 1) == 0);
        end

        repeat (2) step(0, 0, 0, 0, 32'd0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
